// File: rtl/memory_stage.sv
// memory_stage: LW/SW access stage with ready handshake, timeout abort and registered write-back
module memory_stage #(
  parameter int DATA_W  = 16,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  input  logic [DATA_W-1:0] aluResult,
  input  logic [DATA_W-1:0] writeData,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic              RegWrite,
  output logic              stall,
  output logic              mem_en,
  output logic              mem_wr,
  output logic [DATA_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ready,
  output logic              wb_valid,
  output logic              wb_we,
  output logic [DATA_W-1:0] wb_data,
  output logic              err
);
  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;
  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);
  state_t state;
  logic [7:0] cnt;
  logic mem_op;
  assign mem_op = MemRead | MemWrite;
  // upstream must hold a memory instruction until DONE frees the stage
  assign stall = (state == IDLE && in_valid && mem_op) || state == WAIT;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      mem_en    <= 1'b0;
      mem_wr    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wb_valid  <= 1'b0;
      wb_we     <= 1'b0;
      wb_data   <= '0;
      err       <= 1'b0;
    end else begin
      wb_valid <= 1'b0;
      wb_we    <= 1'b0;
      err      <= 1'b0;
      case (state)
        IDLE: if (in_valid) begin
          if (!mem_op) begin
            wb_valid <= 1'b1;
            wb_we    <= RegWrite;
            wb_data  <= aluResult;
          end else if (aluResult[0]) begin
            state    <= DONE;
            wb_valid <= 1'b1;
            wb_we    <= !MemWrite;
            wb_data  <= '0;
            err      <= 1'b1;
          end else begin
            state     <= WAIT;
            mem_en    <= 1'b1;
            mem_wr    <= MemWrite;
            mem_addr  <= aluResult;
            mem_wdata <= writeData;
          end
        end
        WAIT: if (mem_ready || cnt == LAST) begin
          state    <= DONE;
          mem_en   <= 1'b0;
          cnt      <= '0;
          wb_valid <= 1'b1;
          wb_we    <= !mem_wr;
          wb_data  <= (mem_ready && !mem_wr) ? mem_rdata : '0;
          err      <= !mem_ready;
        end else begin
          cnt <= cnt + 8'd1;
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_memory_stage.sv
// tb_memory_stage: randomized transaction-level checks of memory_stage against a behavioural model
module tb_memory_stage;
  localparam int TO = 4;
  logic        clk = 0, rst_n = 0;
  logic        in_valid = 0, MemRead = 0, MemWrite = 0, RegWrite = 0;
  logic [15:0] aluResult = 0, writeData = 0, mem_rdata = 0;
  logic        mem_ready = 0;
  logic        stall, mem_en, mem_wr, wb_valid, wb_we, err;
  logic [15:0] mem_addr, mem_wdata, wb_data;
  logic [15:0] mem_model [256];
  int vectors = 0, miscompares = 0;

  memory_stage #(.DATA_W(16), .TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .aluResult(aluResult),
    .writeData(writeData), .MemRead(MemRead), .MemWrite(MemWrite), .RegWrite(RegWrite),
    .stall(stall), .mem_en(mem_en), .mem_wr(mem_wr), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .wb_valid(wb_valid), .wb_we(wb_we), .wb_data(wb_data), .err(err)
  );

  always #5 clk = ~clk;

  // one instruction; lat = WAIT cycles before mem_ready (>= TO means memory never answers)
  task automatic do_instr(input string name, input logic rd, input logic wr, input logic rw,
                          input logic [15:0] a, input logic [15:0] wd, input int lat);
    bit memop, mis, tmo, got, exp_we, exp_err;
    int exp_mcyc, exp_lat, cyc, mcnt;
    logic [15:0] exp_data;
    memop    = rd | wr;
    mis      = memop && a[0];
    tmo      = memop && !mis && lat >= TO;
    exp_mcyc = (!memop || mis) ? 0 : tmo ? TO : lat + 1;
    exp_lat  = exp_mcyc + 1;
    exp_data = !memop ? a : (mis || tmo || wr) ? 16'h0 : mem_model[a[8:1]];
    exp_we   = !memop ? rw : !wr;
    exp_err  = mis || tmo;
    in_valid = 1; MemRead = rd; MemWrite = wr; RegWrite = rw; aluResult = a; writeData = wd;
    #1;
    if (!mis) begin
      vectors++;
      if (stall !== memop) begin
        miscompares++;
        $display("FAIL %s accept_stall: got %b want %b", name, stall, memop);
      end
    end
    cyc = 0; mcnt = 0; got = 0;
    while (!got && cyc < 300) begin
      @(posedge clk); #1; cyc++;
      if (wb_valid) got = 1;
      else begin
        mem_ready = 0;
        mem_rdata = 16'($urandom);
        in_valid = 1'($urandom); MemRead = 1'($urandom); MemWrite = 1'($urandom);
        aluResult = 16'($urandom); writeData = 16'($urandom);
        if (mem_en) begin
          vectors++;
          if ({mem_addr, mem_wr, mem_wdata, stall} !== {a, wr, wd, 1'b1}) begin
            miscompares++;
            $display("FAIL %s wait_bus: got addr=%h wr=%b wdata=%h stall=%b want addr=%h wr=%b wdata=%h stall=1",
                     name, mem_addr, mem_wr, mem_wdata, stall, a, wr, wd);
          end
          if (!tmo && memop && !mis && mcnt == lat) begin
            mem_ready = 1;
            mem_rdata = mem_model[a[8:1]];
            if (wr) mem_model[a[8:1]] = wd;
          end
          mcnt++;
        end
      end
    end
    vectors++;
    if (!got || cyc != exp_lat) begin
      miscompares++;
      $display("FAIL %s wb_latency: got %0d (seen=%b) want %0d", name, cyc, got, exp_lat);
    end
    vectors++;
    if ({wb_we, wb_data, err, stall, mem_en} !== {exp_we, exp_data, exp_err, 1'b0, 1'b0}) begin
      miscompares++;
      $display("FAIL %s wb: got we=%b data=%h err=%b stall=%b mem_en=%b want we=%b data=%h err=%b stall=0 mem_en=0",
               name, wb_we, wb_data, err, stall, mem_en, exp_we, exp_data, exp_err);
    end
    vectors++;
    if (mcnt != exp_mcyc) begin
      miscompares++;
      $display("FAIL %s mem_en_cycles: got %0d want %0d", name, mcnt, exp_mcyc);
    end
    in_valid = 0; MemRead = 0; MemWrite = 0;
    mem_ready = 1'($urandom);
    @(posedge clk); #1;
    vectors++;
    if ({wb_valid, err, stall, mem_en} !== 4'b0) begin
      miscompares++;
      $display("FAIL %s idle_after: got wb_valid=%b err=%b stall=%b mem_en=%b want all 0",
               name, wb_valid, err, stall, mem_en);
    end
    mem_ready = 0;
  endtask

  task automatic test_reset();
    rst_n = 0;
    #1;
    vectors++;
    if ({stall, mem_en, mem_wr, mem_addr, mem_wdata, wb_valid, wb_we, wb_data, err} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: got stall=%b mem_en=%b mem_wr=%b addr=%h wdata=%h wb_valid=%b wb_we=%b wb_data=%h err=%b want all 0",
               stall, mem_en, mem_wr, mem_addr, mem_wdata, wb_valid, wb_we, wb_data, err);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_directed();
    do_instr("alu_pass", 0, 0, 1, 16'h0008, 16'h0, 0);
    mem_model[8'h08] = 16'hBEEF;
    do_instr("lw_zero_wait", 1, 0, 1, 16'h0010, 16'h0, 0);
    do_instr("sw_3cycle", 0, 1, 0, 16'h0020, 16'h1234, 2);
    do_instr("lw_after_sw", 1, 0, 1, 16'h0020, 16'h0, 1);
    do_instr("lw_misaligned", 1, 0, 1, 16'h0011, 16'h0, 0);
    do_instr("sw_misaligned", 0, 1, 1, 16'h0033, 16'h5555, 0);
    do_instr("lw_timeout", 1, 0, 1, 16'h0040, 16'h0, 50);
    do_instr("sw_timeout", 0, 1, 0, 16'h0042, 16'hAAAA, TO);
    do_instr("both_is_sw", 1, 1, 1, 16'h0044, 16'h7777, 1);
    do_instr("lw_both_check", 1, 0, 1, 16'h0044, 16'h0, 3);
  endtask

  task automatic test_back_to_back();
    logic [15:0] a;
    logic rw;
    for (int i = 0; i < 10; i++) begin
      a = 16'($urandom); rw = 1'($urandom);
      in_valid = 1; MemRead = 0; MemWrite = 0; aluResult = a; RegWrite = rw;
      @(posedge clk); #1;
      vectors++;
      if ({wb_valid, wb_we, wb_data, stall} !== {1'b1, rw, a, 1'b0}) begin
        miscompares++;
        $display("FAIL b2b_alu[%0d]: got valid=%b we=%b data=%h stall=%b want valid=1 we=%b data=%h stall=0",
                 i, wb_valid, wb_we, wb_data, stall, rw, a);
      end
    end
    in_valid = 0;
    @(posedge clk); #1;
    vectors++;
    if (wb_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_idle: got wb_valid=%b want 0", wb_valid);
    end
  endtask

  task automatic test_reset_mid_access();
    int seen;
    in_valid = 1; MemRead = 1; MemWrite = 0; RegWrite = 1; aluResult = 16'h0060;
    @(posedge clk); #1;
    in_valid = 0; MemRead = 0;
    @(posedge clk); #1;
    vectors++;
    if ({mem_en, stall} !== 2'b11) begin
      miscompares++;
      $display("FAIL rst_mid_wait: got mem_en=%b stall=%b want 1 1", mem_en, stall);
    end
    rst_n = 0;
    #1;
    vectors++;
    if ({mem_en, stall} !== 2'b00) begin
      miscompares++;
      $display("FAIL rst_mid_drop: got mem_en=%b stall=%b want 0 0", mem_en, stall);
    end
    @(posedge clk); #1;
    rst_n = 1;
    seen = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (wb_valid) seen++;
    end
    vectors++;
    if (seen != 0) begin
      miscompares++;
      $display("FAIL rst_mid_no_wb: got %0d wb_valid pulses want 0", seen);
    end
    do_instr("lw_after_reset", 1, 0, 1, 16'h0060, 16'h0, 3);
  endtask

  task automatic test_random();
    logic [15:0] a, wd;
    int op, lat;
    for (int i = 0; i < 80; i++) begin
      a = 16'($urandom_range(0, 511));
      if ($urandom_range(0, 3) != 0) a[0] = 1'b0;
      wd  = 16'($urandom);
      op  = $urandom_range(0, 3);
      lat = $urandom_range(0, TO + 1);
      do_instr($sformatf("rand%0d", i), op == 1 || op == 3, op >= 2, 1'($urandom), a, wd, lat);
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem_model[i] = 16'($urandom);
    test_reset();
    test_directed();
    test_back_to_back();
    test_reset_mid_access();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/memory_stage.md
Name: memory_stage

Overview:
- Memory-access stage directly downstream of the execute stage of the 16-bit single-cycle datapath.
- Consumes aluResult (address or ALU value), writeData (store data) and the LW/SW control bits.
- Runs a request/ready handshake with a variable-latency data memory and stalls upstream while an access is outstanding.
- Delivers registered write-back data with flags for the register file.

Parameters:
DATA_W, 16, data and address width
TIMEOUT, 255, max cycles waiting on mem_ready before an access is aborted (1..255)

Ports:
clk  in  1  system clock, rising edge
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  execute-stage outputs valid this cycle
aluResult  in  16  ALU result; byte address for LW/SW
writeData  in  16  store data for SW
MemRead  in  1  LW
MemWrite  in  1  SW
RegWrite  in  1  instruction writes a register
stall  out  1  hold upstream stages
mem_en  out  1  memory request
mem_wr  out  1  1=write, 0=read
mem_addr  out  16  memory word address (byte address, bit0=0)
mem_wdata  out  16  memory write data
mem_rdata  in  16  memory read data, valid with mem_ready
mem_ready  in  1  memory completes current request
wb_valid  out  1  write-back data valid (1-cycle pulse)
wb_we  out  1  register-file write enable, qualified by wb_valid
wb_data  out  16  write-back value
err  out  1  1-cycle pulse: misaligned access or timeout

Behaviour:
- Reset (async, rst_n=0): state=IDLE. stall, mem_en, mem_wr, wb_valid, wb_we and err=0. mem_addr, mem_wdata and wb_data=16'h0000. Timeout counter=0. Takes effect immediately, including mid-access; the in-flight access is abandoned with no write-back.
- States: IDLE, WAIT, DONE.
- IDLE, in_valid=1, MemRead=MemWrite=0 (ALU op):
  - Next cycle: wb_valid=1, wb_data=aluResult, wb_we=RegWrite.
  - Latency 1, no stall, back-to-back accepted every cycle.
- IDLE, in_valid=1, MemRead or MemWrite, aluResult[0]=0:
  - stall=1 combinationally in the same cycle.
  - Latch address, data and op; go to WAIT.
  - In WAIT: mem_en=1, mem_wr=MemWrite, mem_addr and mem_wdata held stable until mem_ready is sampled high.
- IDLE, memory op with aluResult[0]=1 (misaligned):
  - No memory request. Go to DONE with err=1.
  - LW: wb_data=0, wb_we=1. SW: wb_we=0.
- MemRead and MemWrite both 1: treated as SW.
- in_valid=0 in IDLE: no action, wb_valid=0.
- WAIT:
  - stall=1. Counter increments each cycle mem_ready=0.
  - mem_ready=1: capture mem_rdata (LW), mem_en=0 next cycle, go to DONE.
  - Counter reaches TIMEOUT with mem_ready still 0: drop mem_en, go to DONE with err=1. LW writes back 0, SW writes nothing.
- DONE (one cycle):
  - wb_valid=1; wb_data=read data (LW) or 0 (SW).
  - wb_we=1 for LW, 0 for SW.
  - stall=0. Return to IDLE; counter cleared.
  - Upstream presents the next instruction in this cycle, and it is sampled by IDLE the following cycle.
- Access latency: mem_ready high on the first WAIT cycle gives wb_valid 2 cycles after acceptance.
- mem_ready while not in WAIT: ignored.
- Inputs are ignored whenever state is not IDLE.
- Counter is 8-bit; it must not wrap before TIMEOUT.

Test Plan:
- ALU pass-through: in_valid=1, RegWrite=1, aluResult=16'h0008, no mem op -> next cycle wb_valid=1, wb_we=1, wb_data=16'h0008, stall=0 throughout.
- LW, zero-wait: aluResult=16'h0010, MemRead=1, mem_ready=1 on first WAIT cycle, mem_rdata=16'hBEEF -> mem_addr=16'h0010, mem_wr=0, stall high 2 cycles, wb_data=16'hBEEF, wb_we=1.
- SW, 3-cycle memory: aluResult=16'h0020, writeData=16'h1234, MemWrite=1, mem_ready after 3 cycles -> mem_wdata=16'h1234 stable for all 3 cycles, mem_wr=1, wb_valid=1 with wb_we=0, err=0.
- Misaligned LW: aluResult=16'h0011, MemRead=1 -> mem_en never 1, err=1 pulse, wb_data=0, wb_we=1.
- Timeout: TIMEOUT=4, LW with mem_ready stuck 0 -> mem_en high exactly 4 cycles, then err=1 and wb_data=0 in DONE, IDLE the cycle after.
- Reset mid-access: LW in WAIT, rst_n=0 for 1 cycle -> mem_en and stall drop immediately, no wb_valid; the next LW completes normally.
